// File: rtl/sevenseg_mux_driver.sv
// Multiplexed seven-segment driver with frame-synchronous display update
// and optional leading-zero blanking.
module sevenseg_mux_driver #(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 100000,
   parameter bit ACTIVE_LOW  = 1'b1
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic [4*NUM_DIGITS-1:0] bcd_i,
   input  logic [NUM_DIGITS-1:0]   dp_i,
   input  logic                    load_i,
   output logic                    ready_o,
   input  logic                    blank_lz_i,
   output logic [6:0]              seg_o,
   output logic                    dp_o,
   output logic [NUM_DIGITS-1:0]   an_o,
   output logic                    frame_o
);

   localparam int CW = $clog2(REFRESH_DIV);
   localparam int IW = $clog2(NUM_DIGITS);
   localparam int DW = 4 * NUM_DIGITS;
   localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
   localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);
   localparam logic POL = ACTIVE_LOW;

   logic [CW-1:0]         cnt_q, cnt_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [DW-1:0]         pend_bcd_q, disp_bcd_q;
   logic [NUM_DIGITS-1:0] pend_dp_q, disp_dp_q;
   logic                  pend_vld_q;
   logic                  bnd_q;
   logic [6:0]            seg_q, seg_d;
   logic                  dp_q, dp_d;
   logic [NUM_DIGITS-1:0] an_q, an_d;
   logic                  frame_q;

   logic                  tick, boundary;
   logic [3:0]            digit;
   logic                  digit_dp;
   logic                  nonzero_hi;
   logic                  blank;
   logic [6:0]            seg_lit;
   logic [NUM_DIGITS-1:0] an_lit;

   assign tick     = (cnt_q == CNT_MAX);
   assign boundary = tick && (idx_q == IDX_MAX);
   assign cnt_d    = tick ? '0 : cnt_q + CW'(1);

   always_comb begin
      idx_d = idx_q;
      if (tick) begin
         idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IW'(1);
      end
   end

   // Select the active digit and see whether it or any higher digit is nonzero.
   always_comb begin
      digit      = 4'd0;
      digit_dp   = 1'b0;
      nonzero_hi = 1'b0;
      an_lit     = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (i == int'(idx_q)) begin
            digit     = disp_bcd_q[4*i +: 4];
            digit_dp  = disp_dp_q[i];
            an_lit[i] = 1'b1;
         end
         if (i >= int'(idx_q) && disp_bcd_q[4*i +: 4] != 4'd0) begin
            nonzero_hi = 1'b1;
         end
      end
   end

   assign blank = blank_lz_i && (idx_q != '0) && !nonzero_hi;

   always_comb begin
      seg_lit = 7'b1000000;
      case (digit)
         4'd0:    seg_lit = 7'b0111111;
         4'd1:    seg_lit = 7'b0000110;
         4'd2:    seg_lit = 7'b1011011;
         4'd3:    seg_lit = 7'b1001111;
         4'd4:    seg_lit = 7'b1100110;
         4'd5:    seg_lit = 7'b1101101;
         4'd6:    seg_lit = 7'b1111101;
         4'd7:    seg_lit = 7'b0000111;
         4'd8:    seg_lit = 7'b1111111;
         4'd9:    seg_lit = 7'b1100111;
         default: seg_lit = 7'b1000000;
      endcase
   end

   assign seg_d = (blank ? 7'b0 : seg_lit) ^ {7{POL}};
   assign dp_d  = (digit_dp && !blank) ^ POL;
   assign an_d  = an_lit ^ {NUM_DIGITS{POL}};

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q      <= '0;
         idx_q      <= '0;
         pend_bcd_q <= '0;
         pend_dp_q  <= '0;
         pend_vld_q <= 1'b0;
         disp_bcd_q <= '0;
         disp_dp_q  <= '0;
         bnd_q      <= 1'b0;
         seg_q      <= {7{POL}};
         dp_q       <= POL;
         an_q       <= {NUM_DIGITS{POL}};
         frame_q    <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         bnd_q   <= boundary;
         seg_q   <= seg_d;
         dp_q    <= dp_d;
         an_q    <= an_d;
         frame_q <= bnd_q;
         // A capture taken on a boundary edge waits for the next boundary.
         if (boundary && pend_vld_q) begin
            disp_bcd_q <= pend_bcd_q;
            disp_dp_q  <= pend_dp_q;
            pend_vld_q <= 1'b0;
         end else if (load_i && !pend_vld_q) begin
            pend_bcd_q <= bcd_i;
            pend_dp_q  <= dp_i;
            pend_vld_q <= 1'b1;
         end
      end
   end

   assign ready_o = !pend_vld_q;
   assign seg_o   = seg_q;
   assign dp_o    = dp_q;
   assign an_o    = an_q;
   assign frame_o = frame_q;

endmodule

// File: tb/tb_sevenseg_mux_driver.sv
// Directed bench for sevenseg_mux_driver: active-low instance plus an
// active-high instance sharing the same stimulus.
module tb_sevenseg_mux_driver;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] bcd = 16'h0;
   logic [3:0]  dpi = 4'h0;
   logic        load = 1'b0;
   logic        blank_lz = 1'b0;

   logic       ready, dp, frame;
   logic [6:0] seg;
   logic [3:0] an;
   logic       ready0, dp0, frame0;
   logic [6:0] seg0;
   logic [3:0] an0;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   always #5 clk = ~clk;

   sevenseg_mux_driver #(
      .NUM_DIGITS(4), .REFRESH_DIV(4), .ACTIVE_LOW(1'b1)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n), .bcd_i(bcd), .dp_i(dpi),
      .load_i(load), .ready_o(ready), .blank_lz_i(blank_lz),
      .seg_o(seg), .dp_o(dp), .an_o(an), .frame_o(frame)
   );

   sevenseg_mux_driver #(
      .NUM_DIGITS(4), .REFRESH_DIV(4), .ACTIVE_LOW(1'b0)
   ) dut0 (
      .clk_i(clk), .rst_ni(rst_n), .bcd_i(bcd), .dp_i(dpi),
      .load_i(load), .ready_o(ready0), .blank_lz_i(blank_lz),
      .seg_o(seg0), .dp_o(dp0), .an_o(an0), .frame_o(frame0)
   );

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic go(input int n);
      while (cyc < n) step();
   endtask

   task automatic chk(input string tag, input logic [15:0] got,
                      input logic [15:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_seg", 16'(seg), 16'h7F);
      chk("rst_dp", 16'(dp), 16'h1);
      chk("rst_an", 16'(an), 16'hF);
      chk("rst_frame", 16'(frame), 16'h0);
      chk("rst_ready", 16'(ready), 16'h1);
      chk("rst_seg0", 16'(seg0), 16'h00);
      chk("rst_an0", 16'(an0), 16'h0);
      rst_n = 1'b1;
      cyc = 0;

      step();
      chk("c1_an", 16'(an), 16'hE);
      chk("c1_seg", 16'(seg), 16'h40);
      chk("c1_ready", 16'(ready), 16'h1);
      bcd = 16'h1234;
      load = 1'b1;
      step();
      load = 1'b0;
      chk("c2_ready", 16'(ready), 16'h0);
      go(5);
      bcd = 16'h9999;
      load = 1'b1;
      step();
      load = 1'b0;
      go(15);
      chk("c15_ready", 16'(ready), 16'h0);
      step();
      chk("c16_ready", 16'(ready), 16'h1);
      chk("c16_an", 16'(an), 16'h7);
      chk("c16_seg", 16'(seg), 16'h40);
      chk("c16_frame", 16'(frame), 16'h0);
      step();
      chk("c17_frame", 16'(frame), 16'h1);
      chk("c17_an", 16'(an), 16'hE);
      chk("c17_seg", 16'(seg), 16'h19);
      step();
      chk("c18_frame", 16'(frame), 16'h0);
      go(21);
      chk("c21_an", 16'(an), 16'hD);
      chk("c21_seg", 16'(seg), 16'h30);
      go(25);
      chk("c25_an", 16'(an), 16'hB);
      chk("c25_seg", 16'(seg), 16'h24);
      go(29);
      chk("c29_an", 16'(an), 16'h7);
      chk("c29_seg", 16'(seg), 16'h79);

      go(33);
      blank_lz = 1'b1;
      bcd = 16'h0070;
      load = 1'b1;
      step();
      load = 1'b0;
      go(49);
      chk("lz_d0_an", 16'(an), 16'hE);
      chk("lz_d0_seg", 16'(seg), 16'h40);
      go(53);
      chk("lz_d1_seg", 16'(seg), 16'h78);
      go(57);
      chk("lz_d2_an", 16'(an), 16'hB);
      chk("lz_d2_seg", 16'(seg), 16'h7F);
      chk("lz_d2_dp", 16'(dp), 16'h1);
      go(61);
      chk("lz_d3_an", 16'(an), 16'h7);
      chk("lz_d3_seg", 16'(seg), 16'h7F);

      go(65);
      bcd = 16'hA00F;
      dpi = 4'b0010;
      load = 1'b1;
      step();
      load = 1'b0;
      go(81);
      chk("err_d0_seg", 16'(seg), 16'h3F);
      go(85);
      chk("err_d1_seg", 16'(seg), 16'h40);
      chk("err_d1_dp", 16'(dp), 16'h0);
      go(89);
      chk("err_d2_seg", 16'(seg), 16'h40);
      chk("err_d2_dp", 16'(dp), 16'h1);
      go(93);
      chk("err_d3_seg", 16'(seg), 16'h3F);

      go(95);
      blank_lz = 1'b0;
      bcd = 16'h0008;
      dpi = 4'b0000;
      load = 1'b1;
      step();
      load = 1'b0;
      chk("bnd_ready", 16'(ready), 16'h0);
      step();
      chk("bnd_old_seg", 16'(seg), 16'h3F);
      chk("bnd_old_an", 16'(an), 16'hE);
      go(111);
      chk("bnd_c111_ready", 16'(ready), 16'h0);
      step();
      chk("bnd_c112_ready", 16'(ready), 16'h1);
      step();
      chk("bnd_new_seg", 16'(seg), 16'h00);
      chk("bnd_frame", 16'(frame), 16'h1);
      chk("ah_seg", 16'(seg0), 16'h7F);
      chk("ah_an", 16'(an0), 16'h1);
      chk("ah_frame", 16'(frame0), 16'h1);

      go(115);
      bcd = 16'h5555;
      load = 1'b1;
      step();
      load = 1'b0;
      go(117);
      chk("mr_ready_pre", 16'(ready), 16'h0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mr_seg", 16'(seg), 16'h7F);
      chk("mr_an", 16'(an), 16'hF);
      chk("mr_dp", 16'(dp), 16'h1);
      chk("mr_frame", 16'(frame), 16'h0);
      chk("mr_ready", 16'(ready), 16'h1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc = 0;
      step();
      chk("pr_c1_seg", 16'(seg), 16'h40);
      chk("pr_c1_an", 16'(an), 16'hE);
      chk("pr_c1_ready", 16'(ready), 16'h1);
      go(5);
      chk("pr_c5_an", 16'(an), 16'hD);
      chk("pr_c5_seg", 16'(seg), 16'h40);
      go(16);
      chk("pr_c16_frame", 16'(frame), 16'h0);
      step();
      chk("pr_c17_frame", 16'(frame), 16'h1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
